// File: rtl/counter_mod.sv
// Up/down counter with programmable modulus (limit+1), variable step, load,
// wrap/saturate choice, sticky overflow/underflow flags and a terminal-count pulse.
module counter_mod #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              updown,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [EW-1:0]    w_lim;
  logic [EW-1:0]    w_m;
  logic [EW-1:0]    w_cur;
  logic [EW-1:0]    w_step;
  logic [EW-1:0]    w_s;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    w_diff;
  logic [EW-1:0]    w_wrap_up;
  logic [EW-1:0]    w_wrap_dn;
  logic [WIDTH-1:0] w_nxt;
  logic             w_ev_ovf;
  logic             w_ev_unf;

  // All arithmetic is one bit wider than the count so modulus limit+1 never truncates.
  assign w_lim     = EW'(limit);
  assign w_m       = w_lim + EW'(1);
  assign w_cur     = EW'(r_out);
  assign w_step    = EW'(step);
  assign w_s       = (w_step > w_m) ? w_m : w_step;
  assign w_sum     = w_cur + w_s;
  assign w_diff    = w_cur - w_s;
  assign w_wrap_up = w_sum - w_m;
  assign w_wrap_dn = w_cur + w_m - w_s;

  // Next count and event decode: load > count > hold.
  always_comb begin
    w_nxt    = r_out;
    w_ev_ovf = 1'b0;
    w_ev_unf = 1'b0;
    if (load) begin
      w_nxt = load_val;
    end else if (en && (step != '0)) begin
      if (w_cur > w_lim) begin
        w_ev_ovf = 1'b1;
        w_nxt    = sat ? limit : '0;
      end else if (updown) begin
        if (w_sum <= w_lim) begin
          w_nxt = WIDTH'(w_sum);
        end else begin
          w_ev_ovf = 1'b1;
          w_nxt    = sat ? limit : WIDTH'(w_wrap_up);
        end
      end else begin
        if (w_cur >= w_s) begin
          w_nxt = WIDTH'(w_diff);
        end else begin
          w_ev_unf = 1'b1;
          w_nxt    = sat ? '0 : WIDTH'(w_wrap_dn);
        end
      end
    end
  end

  // A flag event on the same edge as clr_flags keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_out <= w_nxt;
      r_tc  <= w_ev_ovf | w_ev_unf;
      r_ovf <= (r_ovf & ~clr_flags) | w_ev_ovf;
      r_unf <= (r_unf & ~clr_flags) | w_ev_unf;
    end
  end

  assign out    = r_out;
  assign tc     = r_tc;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign at_max = (r_out == limit);
  assign at_min = (r_out == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: directed plan checks plus randomized traffic against
// an integer-arithmetic reference model.
module tb_counter_mod;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              updown;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              sat;
  logic              clr_flags;
  logic [WIDTH-1:0]  out;
  logic              tc;
  logic              ovf;
  logic              unf;
  logic              at_max;
  logic              at_min;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  int m_out;
  bit m_tc, m_ovf, m_unf;

  counter_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .step(step), .limit(limit), .sat(sat),
    .clr_flags(clr_flags), .out(out), .tc(tc), .ovf(ovf), .unf(unf),
    .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: modulus M = limit+1, effective step min(step, M), plain integers.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
    end else begin
      int lim, md, s, nxt;
      bit eo, eu;
      lim = int'(limit);
      md  = lim + 1;
      s   = (int'(step) > md) ? md : int'(step);
      nxt = m_out;
      eo  = 0;
      eu  = 0;
      if (load) begin
        nxt = int'(load_val);
      end else if (en && s != 0) begin
        if (m_out > lim) begin
          eo  = 1;
          nxt = sat ? lim : 0;
        end else if (updown) begin
          if (m_out + s <= lim) nxt = m_out + s;
          else begin eo = 1; nxt = sat ? lim : (m_out + s) % md; end
        end else begin
          if (m_out >= s) nxt = m_out - s;
          else begin eu = 1; nxt = sat ? 0 : (m_out - s + md) % md; end
        end
      end
      if (clr_flags) begin m_ovf = 0; m_unf = 0; end
      if (eo) m_ovf = 1;
      if (eu) m_unf = 1;
      m_tc  = eo | eu;
      m_out = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_out", int'(out), m_out);
      chk("model_tc", int'(tc), int'(m_tc));
      chk("model_ovf", int'(ovf), int'(m_ovf));
      chk("model_unf", int'(unf), int'(m_unf));
      chk("model_at_max", int'(at_max), int'(m_out == int'(limit)));
      chk("model_at_min", int'(at_min), int'(m_out == 0));
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; updown = 1'b1; load = 1'b0; load_val = '0;
    step = '0; limit = 8'd9; sat = 1'b0; clr_flags = 1'b0;
    #12;
    chk("rst_out", int'(out), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    chk("rst_at_min", int'(at_min), 1);
    cmp_on = 1'b1;

    // Plan 1: wrap at modulus 10.
    rst = 1'b1; en = 1'b1; updown = 1'b1; step = 4'd1; sat = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("p1_out", int'(out), i % 10);
      chk("p1_tc", int'(tc), int'(i == 10));
      chk("p1_at_max", int'(at_max), int'(i == 9));
    end
    chk("p1_ovf", int'(ovf), 1);

    // Plan 2: saturate from 6 with step 3.
    load = 1'b1; load_val = 8'd6; clr_flags = 1'b1;
    tick();
    chk("p2_load", int'(out), 6);
    chk("p2_ovf_clr", int'(ovf), 0);
    load = 1'b0; clr_flags = 1'b0; sat = 1'b1; step = 4'd3;
    tick();
    chk("p2_out1", int'(out), 9);
    chk("p2_tc1", int'(tc), 0);
    chk("p2_ovf1", int'(ovf), 0);
    tick();
    chk("p2_out2", int'(out), 9);
    chk("p2_tc2", int'(tc), 1);
    chk("p2_ovf2", int'(ovf), 1);
    tick();
    chk("p2_out3", int'(out), 9);
    chk("p2_tc3", int'(tc), 1);

    // Plan 3: wrap down from 1.
    load = 1'b1; load_val = 8'd1; clr_flags = 1'b1;
    tick();
    load = 1'b0; clr_flags = 1'b0; sat = 1'b0; updown = 1'b0;
    tick();
    chk("p3_out1", int'(out), 8);
    chk("p3_unf", int'(unf), 1);
    chk("p3_tc1", int'(tc), 1);
    tick();
    chk("p3_out2", int'(out), 5);
    chk("p3_tc2", int'(tc), 0);

    // Plan 4: load out of range, then count.
    load = 1'b1; load_val = 8'd200; clr_flags = 1'b1;
    tick();
    chk("p4_load", int'(out), 200);
    chk("p4_tc", int'(tc), 0);
    chk("p4_ovf0", int'(ovf), 0);
    load = 1'b0; clr_flags = 1'b0; updown = 1'b1;
    tick();
    chk("p4_wrap", int'(out), 0);
    chk("p4_ovf", int'(ovf), 1);
    load = 1'b1;
    tick();
    load = 1'b0; sat = 1'b1;
    tick();
    chk("p4_sat", int'(out), 9);

    // Plan 5: asynchronous reset between edges.
    load = 1'b1; load_val = 8'd7; sat = 1'b0;
    tick();
    chk("p5_pre_out", int'(out), 7);
    chk("p5_pre_ovf", int'(ovf), 1);
    load = 1'b0; en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("p5_rst_out", int'(out), 0);
    chk("p5_rst_ovf", int'(ovf), 0);
    #1 rst = 1'b1;
    en = 1'b1; updown = 1'b1; step = 4'd1;
    tick();
    chk("p5_resume", int'(out), 1);

    // Plan 6: clear vs. set priority, zero step.
    load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0;
    tick();
    chk("p6_ovf_set", int'(ovf), 1);
    load = 1'b1;
    tick();
    load = 1'b0; clr_flags = 1'b1;
    tick();
    chk("p6_set_wins", int'(ovf), 1);
    chk("p6_out", int'(out), 0);
    en = 1'b0;
    tick();
    chk("p6_clr", int'(ovf), 0);
    clr_flags = 1'b0; en = 1'b1; step = '0;
    tick();
    chk("p6_hold", int'(out), 0);
    chk("p6_no_tc", int'(tc), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 3) != 0);
      updown    = 1'($urandom_range(0, 1));
      load      = ($urandom_range(0, 15) == 0);
      load_val  = WIDTH'($urandom);
      step      = STEP_W'($urandom);
      sat       = 1'($urandom_range(0, 1));
      clr_flags = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       limit = WIDTH'($urandom);
          1:       limit = WIDTH'($urandom_range(0, 15));
          2:       limit = 8'd255;
          default: limit = 8'd0;
        endcase
      end
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
Parametrised up/down counter, the successor to the fixed-width free-running up/down counter. Adds a programmable modulus (`limit`) and a variable step. It also adds a synchronous load, a count enable, and a runtime choice between wrap and saturate. Sticky overflow/underflow flags and a terminal-count pulse let timers, dividers and address generators in the design share one block.

Parameters:
- WIDTH, 8, counter, load value and limit width in bits (>=2).
- STEP_W, 4, step input width in bits (1 <= STEP_W <= WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- en  in  1  count enable; no count when 0.
- updown  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- step  in  STEP_W  increment/decrement magnitude; 0 = hold.
- limit  in  WIDTH  maximum count; the legal range is 0..limit and the modulus is limit+1.
- sat  in  1  1 = saturate at the bounds, 0 = wrap modulo limit+1.
- clr_flags  in  1  synchronous clear of ovf/unf.
- out  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- at_max  out  1  combinational, out == limit.
- at_min  out  1  combinational, out == 0.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk): out=0, tc=0, ovf=0, unf=0. All registers hold while rst=0. The first count occurs on the first rising clk edge after rst deasserts.
- Priority per edge: load > count (en=1) > hold.
  - load=1: out <= load_val unchanged, even if load_val > limit. tc <= 0. No flag events.
  - en=0 and load=0: out holds, tc <= 0.
  - step=0 with en=1: out holds, no events, tc <= 0.
- Arithmetic is done at WIDTH+1 bits with no intermediate truncation. M = limit+1 (WIDTH+1 bits). The effective step s = min(step, M).
- Out-of-range start (out > limit) with en=1 and step != 0, either direction:
  - This is an overflow event.
  - out <= limit if sat=1, else 0.
- Count up, out <= limit, sum = out + s:
  - If sum <= limit: out <= sum.
  - Otherwise it is an overflow event: out <= limit if sat=1, else sum - M.
- Count down, out <= limit:
  - If out >= s: out <= out - s.
  - Otherwise it is an underflow event: out <= 0 if sat=1, else out + M - s.
- Saturate mode: counting up while already at limit (or down while at 0) with step != 0 is an event every cycle.
- Events:
  - An overflow event sets ovf; an underflow event sets unf.
  - tc <= 1 on the edge where any event occurs, else tc <= 0. tc is high for exactly the cycle following each event and stays high during consecutive events.
- clr_flags=1 clears ovf and unf on the edge. If an event occurs on the same edge, the set wins for that flag.
- limit, sat and updown are sampled every edge; changing them mid-count takes effect on the next edge with no glitch.
- at_max and at_min are decoded from the registered out and the current limit.

Test Plan:
1. WIDTH=8, limit=9, step=1, sat=0, up from 0 for 11 edges -> out 1..9,0,1. tc=1 only in the cycle after the 9->0 edge. ovf=1, at_max=1 while out=9.
2. limit=9, sat=1, step=3, up from 6 -> out 9, then 9, 9. ovf=1; tc=1 on the 2nd and 3rd cycles (held at limit), not after the 6->9 edge.
3. limit=9, sat=0, step=3, down from 1 -> out=8 (1+10-3), unf=1, tc pulse. Next edge out=5, tc=0.
4. load=1, en=1, load_val=200, limit=9 -> out=200, tc=0. Next up edge with sat=0 -> out=0, ovf=1. With sat=1 the same sequence gives out=9.
5. Drive rst=0 between edges mid-count at out=7 with ovf=1 -> out=0 and ovf=0 immediately (before the next edge). Counting resumes from 0 after release.
6. With ovf=1: clr_flags=1 together with a new overflow edge -> ovf stays 1. clr_flags alone -> ovf=0. step=0, en=1 -> out holds, no tc.
